ram_dp_clr: RTL
===============

# ram_dp_clr

Parametrised simple-dual-port inferred RAM with file preload, read-valid tracking, an optional output register stage and a hardware zero-fill engine. Used for the NN weight, bias and activation buffers. Port A is the read/write port, for the loader or the layer write-back. Port B is a read-only port for the MAC datapath. The clear engine wipes activation buffers between inferences without software loops.

## Interface
- ADDR_WIDTH, 10, address bits on both ports
- DATA_WIDTH, 16, word width
- DEPTH, 1024, number of words; must be ≤ 2^ADDR_WIDTH
- FILE_NAME, "", hex init file loaded with $readmemh at elaboration; empty string means no preload (contents X until written/cleared)
- OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency

- clk  in  1  clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- a_en  in  1  port A request
- a_we  in  1  port A write enable (qualified by a_en)
- a_addr  in  ADDR_WIDTH  port A address
- a_wdata  in  DATA_WIDTH  port A write data
- a_rdata  out  DATA_WIDTH  port A read data
- a_rvalid  out  1  a_rdata valid this cycle
- b_en  in  1  port B read request
- b_addr  in  ADDR_WIDTH  port B address
- b_rdata  out  DATA_WIDTH  port B read data
- b_rvalid  out  1  b_rdata valid this cycle
- clr  in  1  start zero-fill (single-cycle pulse)
- busy  out  1  zero-fill in progress

## Operation
- Port A, a_en=1, a_we=1: mem[a_addr] <= a_wdata. Read-first: the same request returns the old word on a_rdata with a_rvalid.
- Port A, a_en=1, a_we=0: plain read.
- Port B, b_en=1: read. If port A writes the same address in the same cycle, b_rdata returns a_wdata (write-first forwarding).
- Out-of-range address (≥ DEPTH): writes are dropped; reads return 0 with rvalid=1.
- rdata holds its last value while no new read completes. rvalid is a per-request strobe, not a level.
- Clear FSM, two states:
  - IDLE --clr--> CLEAR, counter=0.
  - CLEAR: writes 0 to mem[counter], counter++. At counter=DEPTH-1 the final write occurs and the FSM goes to IDLE.
- busy=1 exactly while in CLEAR.
- While busy, a_en and b_en are ignored: no writes, no rvalid.
- clr while busy is ignored. clr and a_en in the same IDLE cycle: clr wins and the port A request is dropped.
- Reset never touches the memory array. Reset asserted mid-clear: FSM goes to IDLE and the partially cleared contents remain.

## Timing
- Reset values: a_rdata=0, b_rdata=0, a_rvalid=0, b_rvalid=0, busy=0, FSM=IDLE, counter=0. Reset also clears the valid pipeline, so in-flight reads are discarded.
- Read latency, request edge to rvalid: 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1). Fully pipelined, one read per port per cycle.
- Write is visible to a port B read issued the same cycle (via forwarding) and to any read issued at a later cycle.
- clr sampled at edge T: busy=1 from T+1. Zero writes cover edges T+1 … T+DEPTH. busy=0 from T+DEPTH+1, and requests are accepted at that edge.
- Reads issued the cycle before clr still complete with their rvalid.
- Counter width is ADDR_WIDTH+1 so DEPTH=2^ADDR_WIDTH terminates without wrap.

## Structure
- Package ram_pkg: clear-FSM state enum (CLR_IDLE, CLR_RUN) and a latency function lat(OUT_REG) used by the RTL and the bench.
- Sub-module ram_clear_fsm: owns state, counter, busy, the clear write address/enable, and request gating. The top level holds the array, port muxing, forwarding and the valid/data pipelines.
- Array is coded as an inferable simple-dual-port block: one write port, since the clear engine shares port A's write path.

## Test plan
- Preload file with word i = i: B reads at 0, 5, 1023 back-to-back → b_rdata 0x0000, 0x0005, 0x03FF on consecutive cycles, each 1 cycle after request (OUT_REG=0) or 2 cycles after (OUT_REG=1).
- A writes 0xBEEF to addr 7 while B reads addr 7 in the same cycle → b_rdata=0xBEEF. A's simultaneous read of 7 returns the old value 0x0007.
- DEPTH=1000, A writes 0x1234 to addr 1010, then B reads 1010 → b_rvalid=1, b_rdata=0. Addr 999 is unchanged.
- Pulse clr, then hold a_en/b_en high with reads throughout → busy high for exactly DEPTH cycles, no rvalid while busy. Afterwards, reads of 0, 512 and DEPTH-1 all return 0.
- Assert reset_n low at clear cycle 100 → busy=0 and rvalid=0 immediately. Afterwards, addr 50 reads 0 and addr 200 reads the preload value 200.
- clr pulsed again at clear cycle 10 → ignored; busy still falls DEPTH cycles after the first pulse.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and helpers for the dual-port clearable RAM.
package ram_pkg;

    typedef enum logic {
        CLR_IDLE,
        CLR_RUN
    } clr_state_e;

    // Request-to-rvalid latency in cycles for a given output-register setting.
    function automatic int lat(input int out_reg);
        return (out_reg != 0) ? 2 : 1;
    endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Zero-fill sequencer: walks every word once, owns busy and gates port requests.
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  a_en,
    input  logic                  b_en,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  a_go,
    output logic                  b_go
);

    // One extra counter bit so DEPTH == 2**ADDR_WIDTH ends without wrapping.
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

    clr_state_e            r_state;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic                  r_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= CLR_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                CLR_IDLE: begin
                    if (clr) begin
                        r_state <= CLR_RUN;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CLR_RUN: begin
                    if (r_cnt == LAST) begin
                        r_state <= CLR_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= CLR_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign clr_we   = (r_state == CLR_RUN);
    assign clr_addr = r_cnt[ADDR_WIDTH-1:0];
    // A clr pulse in idle takes port A's shared write path, so A's request is dropped.
    assign a_go     = a_en & ~r_busy & ~clr;
    assign b_go     = b_en & ~r_busy;

endmodule

// File: rtl/ram_dp_clr.sv
// Simple-dual-port RAM: port A read/write (read-first), port B read-only with
// write-first forwarding from A, optional output register and zero-fill engine.
module ram_dp_clr
    import ram_pkg::*;
#(
    parameter int    ADDR_WIDTH = 10,
    parameter int    DATA_WIDTH = 16,
    parameter int    DEPTH      = 1024,
    parameter string FILE_NAME  = "",
    parameter int    OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_rvalid,
    input  logic                  b_en,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_rvalid,
    input  logic                  clr,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_a_go;
    logic                  w_b_go;

    ram_clear_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_clr (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (clr),
        .a_en     (a_en),
        .b_en     (b_en),
        .busy     (busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr),
        .a_go     (w_a_go),
        .b_go     (w_b_go)
    );

    logic                  w_a_inr;
    logic                  w_b_inr;
    logic                  w_a_wr;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;

    assign w_a_inr = ({1'b0, a_addr} < DEPTH_W);
    assign w_b_inr = ({1'b0, b_addr} < DEPTH_W);
    assign w_a_wr  = w_a_go & a_we & w_a_inr;
    assign w_we    = w_clr_we | w_a_wr;
    assign w_waddr = w_clr_we ? w_clr_addr : a_addr;
    assign w_wdata = w_clr_we ? '0 : a_wdata;

    logic [DATA_WIDTH-1:0] r_a_raw;
    logic [DATA_WIDTH-1:0] r_b_raw;

    // Array block kept reset-free so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_we)   r_mem[w_waddr] <= w_wdata;
        if (w_a_go) r_a_raw        <= r_mem[a_addr];
        if (w_b_go) r_b_raw        <= r_mem[b_addr];
    end

    logic                  r_a_inr;
    logic                  r_b_inr;
    logic                  r_b_fwd;
    logic [DATA_WIDTH-1:0] r_b_fdata;
    logic                  r_a_v1;
    logic                  r_b_v1;

    // Side flags reset to "out of range", which forces rdata to 0 after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_inr   <= 1'b0;
            r_b_inr   <= 1'b0;
            r_b_fwd   <= 1'b0;
            r_b_fdata <= '0;
            r_a_v1    <= 1'b0;
            r_b_v1    <= 1'b0;
        end else begin
            r_a_v1 <= w_a_go;
            r_b_v1 <= w_b_go;
            if (w_a_go) r_a_inr <= w_a_inr;
            if (w_b_go) begin
                r_b_inr   <= w_b_inr;
                r_b_fwd   <= w_a_wr && (a_addr == b_addr);
                r_b_fdata <= a_wdata;
            end
        end
    end

    logic [DATA_WIDTH-1:0] w_a_d1;
    logic [DATA_WIDTH-1:0] w_b_d1;

    assign w_a_d1 = r_a_inr ? r_a_raw : '0;
    assign w_b_d1 = !r_b_inr ? '0 : (r_b_fwd ? r_b_fdata : r_b_raw);

    generate
        if (lat(OUT_REG) == 2) begin : g_oreg
            logic [DATA_WIDTH-1:0] r_a_q;
            logic [DATA_WIDTH-1:0] r_b_q;
            logic                  r_a_v2;
            logic                  r_b_v2;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_a_q  <= '0;
                    r_b_q  <= '0;
                    r_a_v2 <= 1'b0;
                    r_b_v2 <= 1'b0;
                end else begin
                    r_a_v2 <= r_a_v1;
                    r_b_v2 <= r_b_v1;
                    if (r_a_v1) r_a_q <= w_a_d1;
                    if (r_b_v1) r_b_q <= w_b_d1;
                end
            end

            assign a_rdata  = r_a_q;
            assign a_rvalid = r_a_v2;
            assign b_rdata  = r_b_q;
            assign b_rvalid = r_b_v2;
        end else begin : g_noreg
            assign a_rdata  = w_a_d1;
            assign a_rvalid = r_a_v1;
            assign b_rdata  = w_b_d1;
            assign b_rvalid = r_b_v1;
        end
    endgenerate

endmodule
